spam1_cpu_core: RTL and testbench

Single-clock, 8-bit-data, 16-bit-address SPAM-1 CPU core executing one 48-bit horizontal-microcode instruction per clock. It fetches from an external program ROM, operates on four general registers, two memory-address registers and external data RAM, and talks to a byte UART through ready/strobe handshakes. It is the top compute block of the SPAM-1 system; ROM, RAM and UART sit outside it.

---
 rtl/spam1_cpu_core.sv | 218 +++++++++++++++++++++
 tb/tb_spam1_cpu_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spam1_cpu_core.sv
// spam1_cpu_core: single-cycle SPAM-1 core, one 48-bit microcode word per clock.
// Define SPAM1_HALT_EN to make the halt target stop the core until reset.
module spam1_cpu_core (
  input  logic        clk,
  input  logic        reset_switch,
  output logic [15:0] rom_addr,
  input  logic [47:0] rom_data,
  output logic [15:0] ram_addr,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready,
  output logic        uart_rx_rd,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        uart_tx_wr,
  output logic        halted
);
  logic [15:0] r_pc;
  logic [7:0]  r_rega, r_regb, r_regc, r_regd;
  logic [7:0]  r_marlo, r_marhi, r_pchitmp;
  logic        r_c, r_z, r_o, r_n, r_eq, r_gt, r_lt;

  logic [7:0]  w_imm;
  logic [15:0] w_addr;
  logic        w_amode, w_inv, w_setf;
  logic [3:0]  w_csel;
  logic [2:0]  w_srca, w_srcb;
  logic [4:0]  w_tgt, w_op;
  logic        w_unused_rsvd;

  assign w_imm         = rom_data[7:0];
  assign w_addr        = rom_data[23:8];
  assign w_amode       = rom_data[24];
  assign w_inv         = rom_data[25];
  assign w_setf        = rom_data[26];
  assign w_csel        = rom_data[30:27];
  assign w_srcb        = rom_data[33:31];
  assign w_srca        = rom_data[36:34];
  assign w_tgt         = rom_data[41:37];
  assign w_op          = rom_data[46:42];
  assign w_unused_rsvd = rom_data[47];

  logic [7:0] w_a, w_b, w_res, w_x, w_y;
  logic [8:0] w_wide;
  logic       w_cin, w_sub, w_arith, w_c, w_o;
  logic       w_craw, w_cond, w_exec, w_halted;

  always_comb begin
    case (w_srca)
      3'd0:    w_a = r_rega;
      3'd1:    w_a = r_regb;
      3'd2:    w_a = r_regc;
      3'd3:    w_a = r_regd;
      3'd4:    w_a = r_marlo;
      3'd5:    w_a = r_marhi;
      3'd6:    w_a = uart_rx_data;
      default: w_a = 8'h00;
    endcase
  end

  always_comb begin
    case (w_srcb)
      3'd0:    w_b = r_rega;
      3'd1:    w_b = r_regb;
      3'd2:    w_b = r_regc;
      3'd3:    w_b = r_regd;
      3'd4:    w_b = r_marlo;
      3'd5:    w_b = r_marhi;
      3'd6:    w_b = w_imm;
      default: w_b = ram_rdata;
    endcase
  end

  // All add/subtract flavours share one 9-bit adder: x +/- y +/- cin.
  always_comb begin
    w_x     = w_a;
    w_y     = w_b;
    w_cin   = 1'b0;
    w_sub   = 1'b0;
    w_arith = 1'b1;
    case (w_op)
      5'd3:    ;
      5'd4:    w_sub = 1'b1;
      5'd5:    begin w_x = w_b; w_y = w_a; w_sub = 1'b1; end
      5'd6:    w_cin = r_c;
      5'd7:    begin w_cin = r_c; w_sub = 1'b1; end
      5'd13:   w_y = 8'h01;
      5'd14:   begin w_y = 8'h01; w_sub = 1'b1; end
      5'd15:   begin w_x = w_b; w_y = 8'h01; end
      5'd16:   begin w_x = w_b; w_y = 8'h01; w_sub = 1'b1; end
      default: w_arith = 1'b0;
    endcase
  end

  always_comb begin
    if (w_sub)
      w_wide = {1'b0, w_x} - {1'b0, w_y} - {8'h00, w_cin};
    else
      w_wide = {1'b0, w_x} + {1'b0, w_y} + {8'h00, w_cin};
  end

  always_comb begin
    w_res = 8'h00;
    w_c   = 1'b0;
    w_o   = 1'b0;
    if (w_arith) begin
      w_res = w_wide[7:0];
      w_c   = w_wide[8];
      w_o   = (w_sub ? (w_x[7] != w_y[7]) : (w_x[7] == w_y[7]))
              && (w_res[7] != w_x[7]);
    end else begin
      case (w_op)
        5'd1:    w_res = w_a;
        5'd2:    w_res = w_b;
        5'd8:    w_res = w_a & w_b;
        5'd9:    w_res = w_a | w_b;
        5'd10:   w_res = w_a ^ w_b;
        5'd11:   w_res = ~w_a;
        5'd12:   w_res = ~w_b;
        5'd17:   w_res = {w_a[6:0], 1'b0};
        5'd18:   w_res = {1'b0, w_a[7:1]};
        default: w_res = 8'h00;
      endcase
    end
  end

  always_comb begin
    case (w_csel)
      4'd0:    w_craw = 1'b1;
      4'd1:    w_craw = r_c;
      4'd2:    w_craw = r_z;
      4'd3:    w_craw = r_o;
      4'd4:    w_craw = r_n;
      4'd5:    w_craw = r_eq;
      4'd6:    w_craw = ~r_eq;
      4'd7:    w_craw = r_gt;
      4'd8:    w_craw = r_lt;
      4'd9:    w_craw = uart_rx_ready;
      4'd10:   w_craw = uart_tx_ready;
      default: w_craw = 1'b0;
    endcase
  end

  assign w_cond = w_craw ^ w_inv;
  assign w_exec = w_cond && !w_halted && !reset_switch;

`ifdef SPAM1_HALT_EN
  logic r_halted;
  always_ff @(posedge clk) begin
    if (reset_switch)
      r_halted <= 1'b0;
    else if (w_exec && w_tgt == 5'd8)
      r_halted <= 1'b1;
  end
  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  assign halted       = w_halted;
  assign rom_addr     = r_pc;
  assign ram_addr     = w_amode ? w_addr : {r_marhi, r_marlo};
  assign ram_wdata    = w_res;
  assign uart_tx_data = w_res;
  assign ram_we       = w_exec && w_tgt == 5'd7;
  assign uart_tx_wr   = w_exec && w_tgt == 5'd6;
  assign uart_rx_rd   = w_exec && w_srca == 3'd6;

  always_ff @(posedge clk) begin
    if (reset_switch) begin
      r_pc      <= 16'h0000;
      r_rega    <= 8'h00;
      r_regb    <= 8'h00;
      r_regc    <= 8'h00;
      r_regd    <= 8'h00;
      r_marlo   <= 8'h00;
      r_marhi   <= 8'h00;
      r_pchitmp <= 8'h00;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_o       <= 1'b0;
      r_n       <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
    end else if (!w_halted) begin
      r_pc <= r_pc + 16'd1;
      if (w_exec) begin
        if (w_setf) begin
          r_c  <= w_c;
          r_z  <= (w_res == 8'h00);
          r_o  <= w_o;
          r_n  <= w_res[7];
          r_eq <= (w_a == w_b);
          r_gt <= (w_a > w_b);
          r_lt <= (w_a < w_b);
        end
        case (w_tgt)
          5'd0:    r_rega    <= w_res;
          5'd1:    r_regb    <= w_res;
          5'd2:    r_regc    <= w_res;
          5'd3:    r_regd    <= w_res;
          5'd4:    r_marlo   <= w_res;
          5'd5:    r_marhi   <= w_res;
`ifdef SPAM1_HALT_EN
          5'd8:    r_pc      <= r_pc;
`endif
          5'd9:    r_pchitmp <= w_res;
          5'd10:   r_pc      <= {r_pc[15:8], w_res};
          5'd11:   r_pc      <= {r_pchitmp, w_res};
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spam1_cpu_core.sv
// tb_spam1_cpu_core: vector table, poll loop and UART transmit checks for the SPAM-1 core.
// Halt expectations follow SPAM1_HALT_EN.
module tb_spam1_cpu_core;
  localparam int RA = 0, RB = 1, RC = 2, RD = 3, ML = 4, MH = 5;
  localparam int UA = 6, RM = 7, HL = 8, PH = 9, PL = 10, PCT = 11, NOP = 12;
  localparam int SNU = 7, SIM = 6, SRM = 7;

  logic        clk = 1'b0;
  logic        reset_switch = 1'b1;
  logic [15:0] rom_addr;
  logic [47:0] rom_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_ready = 1'b0;
  logic        uart_rx_rd;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready = 1'b0;
  logic        uart_tx_wr;
  logic        halted;

  logic [47:0] ins_drv = 48'h0;
  logic        use_prog = 1'b0;
  logic [47:0] prog [0:15];

  always_comb rom_data = use_prog ? prog[rom_addr[3:0]] : ins_drv;
  always #5 clk = ~clk;

  spam1_cpu_core dut (
    .clk(clk), .reset_switch(reset_switch),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .uart_rx_rd(uart_rx_rd), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready), .uart_tx_wr(uart_tx_wr),
    .halted(halted)
  );

  typedef struct {
    logic [47:0] ins;
    logic        rxr;
    logic [7:0]  rxd;
    logic        txr;
    logic [7:0]  rdata;
    logic [15:0] pc;
    logic        we, tx, rd;
    logic [7:0]  dat;
    logic        chka;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  vec_t cur, e;
  logic [7:0] exp_b[$];
  int n_chk = 0, n_fail = 0;
  int n_tx, n_rd;

  function automatic logic [47:0] mk(input int op, input int tg, input int sa,
      input int sb, input int cd, input logic sf, input logic inv, input logic am,
      input logic [15:0] ad, input logic [7:0] im);
    return {1'b0, 5'(op), 5'(tg), 3'(sa), 3'(sb), 4'(cd), sf, inv, am, ad, im};
  endfunction

  function automatic logic [47:0] f_imm(input int tg, input logic [7:0] v,
      input int cd, input logic inv);
    return mk(2, tg, SNU, SIM, cd, 1'b0, inv, 1'b0, 16'h0, v);
  endfunction

  function automatic logic [47:0] f_op(input int op, input int tg, input int sa,
      input int sb, input logic [7:0] im, input logic sf);
    return mk(op, tg, sa, sb, 0, sf, 1'b0, 1'b0, 16'h0, im);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addf(input logic [47:0] ins, input logic rxr, input logic [7:0] rxd,
      input logic txr, input logic [7:0] rdata, input logic [15:0] pc,
      input logic we, input logic tx, input logic rd, input logic [7:0] dat,
      input logic chka, input logic [15:0] addr);
    vec_t v;
    v.ins = ins; v.rxr = rxr; v.rxd = rxd; v.txr = txr; v.rdata = rdata;
    v.pc = pc; v.we = we; v.tx = tx; v.rd = rd; v.dat = dat;
    v.chka = chka; v.addr = addr;
    tbl.push_back(v);
  endtask

  task automatic addv(input logic [47:0] ins, input logic [15:0] pc,
      input logic tx, input logic [7:0] dat);
    addf(ins, 1'b0, 8'h00, 1'b0, 8'h00, pc, 1'b0, tx, 1'b0, dat, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    use_prog = 1'b0;
    reset_switch = 1'b1;
    ins_drv = mk(1, UA, 6, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00);
    uart_rx_ready = 1'b1;
    uart_tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc", rom_addr, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_tx_wr", 16'(uart_tx_wr), 16'h0);
    chk("rst_rx_rd", 16'(uart_rx_rd), 16'h0);
    chk("rst_ram_we", 16'(ram_we), 16'h0);
    @(posedge clk);
    #1;
    reset_switch = 1'b0;
    uart_rx_ready = 1'b0;
    uart_tx_ready = 1'b0;
  endtask

  task automatic sample_strobes(input string tag);
    if (uart_rx_rd) n_rd++;
    if (uart_tx_wr) begin
      n_tx++;
      if (exp_b.size() == 0)
        chk({tag, "_extra_tx"}, 16'(uart_tx_data), 16'hFFFF);
      else
        chk({tag, "_tx_data"}, 16'(uart_tx_data), 16'(exp_b.pop_front()));
    end
  endtask

  string hello;

  initial begin
    // Register loads, ALU, flags, conditions and RAM addressing.
    addv(f_imm(RB, 8'h02, 0, 0), 16'd0, 0, 8'h00);
    addv(f_imm(RA, 8'h01, 0, 0), 16'd1, 0, 8'h00);
    addv(f_op(1, UA, RA, SIM, 8'h00, 0), 16'd2, 1, 8'h01);
    addv(f_op(2, UA, SNU, RB, 8'h00, 0), 16'd3, 1, 8'h02);
    addv(f_imm(RA, 8'hFF, 0, 0), 16'd4, 0, 8'h00);
    addv(f_op(3, RA, RA, SIM, 8'h01, 1), 16'd5, 0, 8'h00);
    addv(mk(1, UA, RA, SIM, 2, 0, 0, 0, 16'h0, 8'h00), 16'd6, 1, 8'h00);
    addv(f_imm(UA, 8'h77, 2, 1), 16'd7, 0, 8'h00);
    addv(f_imm(UA, 8'h33, 1, 0), 16'd8, 1, 8'h33);
    addv(f_op(6, RC, RA, SIM, 8'h10, 0), 16'd9, 0, 8'h00);
    addv(f_op(1, UA, RC, SIM, 8'h00, 0), 16'd10, 1, 8'h11);
    addv(f_op(4, RA, RA, SIM, 8'h01, 1), 16'd11, 0, 8'h00);
    addv(f_imm(UA, 8'h44, 4, 0), 16'd12, 1, 8'h44);
    addv(f_imm(UA, 8'h45, 8, 1), 16'd13, 0, 8'h00);
    addv(f_imm(RD, 8'h7F, 0, 0), 16'd14, 0, 8'h00);
    addv(f_op(13, RD, RD, SIM, 8'h00, 1), 16'd15, 0, 8'h00);
    addv(mk(1, UA, RD, SIM, 3, 0, 0, 0, 16'h0, 8'h00), 16'd16, 1, 8'h80);
    addv(f_imm(UA, 8'h01, 1, 0), 16'd17, 0, 8'h00);
    addv(f_op(4, NOP, RB, SIM, 8'h02, 1), 16'd18, 0, 8'h00);
    addv(f_imm(UA, 8'h55, 6, 0), 16'd19, 0, 8'h00);
    addv(f_imm(UA, 8'h56, 5, 0), 16'd20, 1, 8'h56);
    addv(f_imm(UA, 8'h57, 7, 0), 16'd21, 0, 8'h00);
    addv(f_imm(MH, 8'h12, 0, 0), 16'd22, 0, 8'h00);
    addv(f_imm(ML, 8'h34, 0, 0), 16'd23, 0, 8'h00);
    addf(f_imm(RM, 8'h5A, 0, 0), 0, 8'h00, 0, 8'h00, 16'd24, 1, 0, 0, 8'h5A, 1, 16'h1234);
    addf(mk(2, RM, SNU, SIM, 0, 0, 0, 1, 16'hBEEF, 8'h66), 0, 8'h00, 0, 8'h00,
         16'd25, 1, 0, 0, 8'h66, 1, 16'hBEEF);
    addf(mk(2, RA, SNU, SRM, 0, 0, 0, 1, 16'h0100, 8'h00), 0, 8'h00, 0, 8'h9C,
         16'd26, 0, 0, 0, 8'h00, 1, 16'h0100);
    addv(f_op(1, UA, RA, SIM, 8'h00, 0), 16'd27, 1, 8'h9C);
    addv(f_op(10, UA, RA, SIM, 8'hFF, 0), 16'd28, 1, 8'h63);
    addv(f_op(17, UA, RA, SIM, 8'h00, 0), 16'd29, 1, 8'h38);
    addv(f_op(18, UA, RA, SIM, 8'h00, 0), 16'd30, 1, 8'h4E);
    addv(f_op(12, UA, SNU, SIM, 8'h0F, 0), 16'd31, 1, 8'hF0);
    addv(f_op(5, UA, RA, SIM, 8'h10, 0), 16'd32, 1, 8'h74);
    addv(f_op(20, UA, RA, SIM, 8'h55, 0), 16'd33, 1, 8'h00);
    addf(f_op(1, RA, 6, SIM, 8'h00, 0), 1, 8'h41, 0, 8'h00, 16'd34, 0, 0, 1, 8'h00, 0, 16'h0);
    addv(f_op(1, UA, RA, SIM, 8'h00, 0), 16'd35, 1, 8'h41);
    addv(f_op(3, NOP, RA, SIM, 8'hFF, 1), 16'd36, 0, 8'h00);
    addv(f_op(7, UA, RA, SIM, 8'h01, 0), 16'd37, 1, 8'h3F);
    addv(f_op(6, UA, RA, SIM, 8'h01, 0), 16'd38, 1, 8'h43);
    addv(f_op(14, UA, RA, SIM, 8'h00, 0), 16'd39, 1, 8'h40);
    addv(f_op(16, UA, SNU, SIM, 8'h00, 0), 16'd40, 1, 8'hFF);
    addv(f_op(8, UA, RA, SIM, 8'h0F, 0), 16'd41, 1, 8'h01);
    addv(f_op(9, UA, RA, SIM, 8'h0F, 0), 16'd42, 1, 8'h4F);
    addv(f_op(11, UA, RA, SIM, 8'h00, 0), 16'd43, 1, 8'hBE);
    addv(f_op(15, UA, SNU, SIM, 8'hFF, 0), 16'd44, 1, 8'h00);
    addv(f_op(0, UA, RA, SIM, 8'h00, 0), 16'd45, 1, 8'h00);
    // Jumps, conditional branches, strobe gating and PC wrap.
    addv(f_imm(PH, 8'h01, 0, 0), 16'd46, 0, 8'h00);
    addv(f_imm(PCT, 8'h40, 0, 0), 16'd47, 0, 8'h00);
    addv(f_imm(PL, 8'hFE, 0, 0), 16'h0140, 0, 8'h00);
    addv(f_imm(NOP, 8'h00, 0, 0), 16'h01FE, 0, 8'h00);
    addv(f_imm(UA, 8'h11, 15, 0), 16'h01FF, 0, 8'h00);
    addf(f_imm(PCT, 8'h00, 9, 0), 0, 8'h00, 0, 8'h00, 16'h0200, 0, 0, 0, 8'h00, 0, 16'h0);
    addf(f_imm(PCT, 8'h00, 9, 1), 0, 8'h00, 0, 8'h00, 16'h0201, 0, 0, 0, 8'h00, 0, 16'h0);
    addf(mk(1, RA, 6, SIM, 15, 0, 0, 0, 16'h0, 8'h00), 1, 8'h77, 0, 8'h00,
         16'h0100, 0, 0, 0, 8'h00, 0, 16'h0);
    addf(f_imm(UA, 8'h21, 10, 0), 0, 8'h00, 1, 8'h00, 16'h0101, 0, 1, 0, 8'h21, 0, 16'h0);
    addf(f_imm(UA, 8'h22, 10, 0), 0, 8'h00, 0, 8'h00, 16'h0102, 0, 0, 0, 8'h00, 0, 16'h0);
    addf(f_imm(UA, 8'h23, 0, 0), 0, 8'h00, 0, 8'h00, 16'h0103, 0, 1, 0, 8'h23, 0, 16'h0);
    addv(f_imm(PH, 8'hFF, 0, 0), 16'h0104, 0, 8'h00);
    addv(f_imm(PCT, 8'hFF, 0, 0), 16'h0105, 0, 8'h00);
    addv(f_imm(NOP, 8'h00, 0, 0), 16'hFFFF, 0, 8'h00);
    addv(f_imm(NOP, 8'h00, 0, 0), 16'h0000, 0, 8'h00);
    addv(f_imm(HL, 8'h00, 0, 0), 16'h0001, 0, 8'h00);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i];
      ins_drv = cur.ins;
      uart_rx_ready = cur.rxr;
      uart_rx_data = cur.rxd;
      uart_tx_ready = cur.txr;
      ram_rdata = cur.rdata;
      sb_q.push_back(cur);
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_pc", i), rom_addr, e.pc);
      chk($sformatf("v%0d_we", i), 16'(ram_we), 16'(e.we));
      chk($sformatf("v%0d_tx_wr", i), 16'(uart_tx_wr), 16'(e.tx));
      chk($sformatf("v%0d_rx_rd", i), 16'(uart_rx_rd), 16'(e.rd));
      chk($sformatf("v%0d_halted", i), 16'(halted), 16'h0);
      if (e.we) chk($sformatf("v%0d_wdata", i), 16'(ram_wdata), 16'(e.dat));
      if (e.tx) chk($sformatf("v%0d_txdata", i), 16'(uart_tx_data), 16'(e.dat));
      if (e.chka) chk($sformatf("v%0d_raddr", i), ram_addr, e.addr);
      @(posedge clk);
      #1;
    end

    // After the halt instruction: frozen core, or a no-op when halting is disabled.
    ins_drv = f_imm(UA, 8'h99, 0, 0);
    uart_tx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
`ifdef SPAM1_HALT_EN
      chk("halt_pc", rom_addr, 16'h0001);
      chk("halt_flag", 16'(halted), 16'h1);
      chk("halt_tx_wr", 16'(uart_tx_wr), 16'h0);
`else
      chk("nohalt_pc", rom_addr, 16'(2 + k));
      chk("nohalt_flag", 16'(halted), 16'h0);
      chk("nohalt_tx_wr", 16'(uart_tx_wr), 16'h1);
`endif
      @(posedge clk);
      #1;
    end

    // Receive poll loop.
    for (int i = 0; i < 16; i++) prog[i] = f_imm(NOP, 8'h00, 0, 0);
    prog[0] = f_imm(PH, 8'h00, 0, 0);
    prog[1] = f_imm(PCT, 8'h00, 9, 1);
    prog[2] = f_op(1, RA, 6, SIM, 8'h00, 0);
    prog[3] = f_op(1, UA, RA, SIM, 8'h00, 0);
    prog[4] = f_imm(PCT, 8'h04, 0, 0);
    do_reset();
    use_prog = 1'b1;
    uart_rx_data = 8'h41;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("poll_pc", rom_addr, 16'(k % 2));
      chk("poll_rx_rd_idle", 16'(uart_rx_rd), 16'h0);
      @(posedge clk);
      #1;
    end
    uart_rx_ready = 1'b1;
    exp_b.push_back(8'h41);
    n_rd = 0;
    n_tx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sample_strobes("poll");
      @(posedge clk);
      #1;
    end
    chk("poll_rx_rd_count", 16'(n_rd), 16'd1);
    chk("poll_tx_count", 16'(n_tx), 16'd1);
    chk("poll_spin_pc", rom_addr, 16'd4);

    // "Hello!\n" with a randomly toggling transmitter ready.
    hello = "Hello!\n";
    for (int i = 0; i < 16; i++) prog[i] = f_imm(NOP, 8'h00, 0, 0);
    prog[0] = f_imm(PH, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) begin
      prog[1 + 2 * i] = f_imm(PCT, 8'(1 + 2 * i), 10, 1);
      prog[2 + 2 * i] = f_imm(UA, hello[i], 0, 0);
    end
    prog[15] = f_imm(PCT, 8'd15, 0, 0);
    do_reset();
    uart_rx_ready = 1'b0;
    use_prog = 1'b1;
    exp_b.delete();
    for (int i = 0; i < 7; i++) exp_b.push_back(hello[i]);
    n_tx = 0;
    n_rd = 0;
    for (int k = 0; k < 200; k++) begin
      uart_tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      sample_strobes("hello");
      @(posedge clk);
      #1;
    end
    chk("hello_tx_count", 16'(n_tx), 16'd7);
    chk("hello_pending", 16'(exp_b.size()), 16'd0);
    chk("hello_end_pc", rom_addr, 16'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
